// File: rtl/scan_defs_pkg.sv
// Shared definitions for the display scan scheduler: state encoding and sizing helpers.
package scan_defs;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    // A width of at least one bit is kept, so a 1- or 2-value range still gets a real vector.
    function automatic int clog2w(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int slot_cycles(input int clk_hz, input int refresh_hz, input int digits);
        return clk_hz / (refresh_hz * digits);
    endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Per-slot cycle counter with the BLANK/DRIVE phase and the slot, blank and frame strobes.
module scan_slot_timer
    import scan_defs::*;
#(
    parameter int SLOT_CYCLES  = 8,
    parameter int BLANK_CYCLES = 2,
    parameter int CW           = 3
) (
    input  logic clkIn,
    input  logic rstNIn,
    input  logic selZeroIn,
    output logic blankEndOut,
    output logic slotEndOut,
    output logic boundaryOut
);

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);

    scan_state_e     state_q;
    logic [CW-1:0]   cnt_q;

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            state_q <= BLANK;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                BLANK: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == BLANK_LAST) state_q <= DRIVE;
                end
                DRIVE: begin
                    if (cnt_q == SLOT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= BLANK;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

    assign blankEndOut = (state_q == BLANK) && (cnt_q == BLANK_LAST);
    assign slotEndOut  = (state_q == DRIVE) && (cnt_q == SLOT_LAST);
    assign boundaryOut = (state_q == BLANK) && (cnt_q == '0) && selZeroIn;

endmodule

// File: rtl/display_scan_scheduler.sv
// Multiplexed seven-segment scan controller with shadowed frame data and req/ack load.
// Optional brightness PWM within the drive window: define SCAN_DIM_PWM_EN.
module display_scan_scheduler
    import scan_defs::*;
#(
    parameter int DIGIT_COUNT   = 8,
    parameter int DATA_WIDTH    = 4,
    parameter int CLK_FREQUENCY = 100000000,
    parameter int REFRESH_RATE  = 1000,
    parameter int BLANK_CYCLES  = 16
) (
    input  logic                              clkIn,
    input  logic                              rstNIn,
`ifdef SCAN_DIM_PWM_EN
    input  logic [3:0]                        dimIn,
`endif
    input  logic [DIGIT_COUNT*DATA_WIDTH-1:0] digitsIn,
    input  logic [DIGIT_COUNT-1:0]            enMaskIn,
    input  logic                              loadReqIn,
    output logic                              loadAckOut,
    output logic [clog2w(DIGIT_COUNT)-1:0]    selOut,
    output logic [DIGIT_COUNT-1:0]            anodeOut,
    output logic [DATA_WIDTH-1:0]             digitOut,
    output logic                              frameStartOut
);

    localparam int SLOT_CYCLES = slot_cycles(CLK_FREQUENCY, REFRESH_RATE, DIGIT_COUNT);
    localparam int CW          = clog2w(SLOT_CYCLES);
    localparam int SW          = clog2w(DIGIT_COUNT);
    localparam logic [SW-1:0] SEL_LAST = SW'(DIGIT_COUNT - 1);

    if (DIGIT_COUNT < 2 || DIGIT_COUNT > 16) begin : g_bad_digits
        $error("display_scan_scheduler: DIGIT_COUNT must be within 2..16");
    end
    if (BLANK_CYCLES < 1 || SLOT_CYCLES <= BLANK_CYCLES + 1) begin : g_bad_slot
        $error("display_scan_scheduler: SLOT_CYCLES must exceed BLANK_CYCLES+1");
    end

    logic [DIGIT_COUNT-1:0][DATA_WIDTH-1:0] shadow_q;
    logic [DIGIT_COUNT-1:0]                 mask_q;
    logic [SW-1:0]                          sel_q;
    logic                                   ack_q;
    logic [DIGIT_COUNT-1:0]                 anode_q, anode_d, drive_pat;
    logic                                   blank_end, slot_end, boundary;

    scan_slot_timer #(
        .SLOT_CYCLES  (SLOT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES),
        .CW           (CW)
    ) u_timer (
        .clkIn       (clkIn),
        .rstNIn      (rstNIn),
        .selZeroIn   (sel_q == '0),
        .blankEndOut (blank_end),
        .slotEndOut  (slot_end),
        .boundaryOut (boundary)
    );

    always_comb begin
        drive_pat = '1;
        if (mask_q[sel_q]) drive_pat[sel_q] = 1'b0;
    end

`ifdef SCAN_DIM_PWM_EN
    localparam int DRIVE_LEN = SLOT_CYCLES - BLANK_CYCLES;

    logic [3:0]    dim_q;
    logic [CW-1:0] on_lim, left_q, left_d;

    assign on_lim = CW'((DRIVE_LEN * (int'(dim_q) + 1)) >> 4);

    // left_q counts the remaining lit cycles after the current one.
    always_comb begin
        anode_d = anode_q;
        left_d  = left_q;
        if (left_q == '0) anode_d = '1;
        else              left_d  = left_q - CW'(1);
        if (blank_end) begin
            anode_d = (on_lim == '0) ? '1 : drive_pat;
            left_d  = (on_lim == '0) ? '0 : on_lim - CW'(1);
        end
        if (slot_end) anode_d = '1;
    end

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            dim_q  <= 4'hF;
            left_q <= '0;
        end else begin
            left_q <= left_d;
            if (boundary) dim_q <= dimIn;
        end
    end
`else
    always_comb begin
        anode_d = anode_q;
        if (blank_end) anode_d = drive_pat;
        if (slot_end)  anode_d = '1;
    end
`endif

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            shadow_q <= '0;
            mask_q   <= '0;
            sel_q    <= '0;
            ack_q    <= 1'b0;
            anode_q  <= '1;
        end else begin
            anode_q <= anode_d;
            ack_q   <= boundary && loadReqIn;
            if (boundary && loadReqIn) begin
                shadow_q <= digitsIn;
                mask_q   <= enMaskIn;
            end
            if (slot_end) sel_q <= (sel_q == SEL_LAST) ? '0 : sel_q + SW'(1);
        end
    end

    assign loadAckOut    = ack_q;
    assign selOut        = sel_q;
    assign anodeOut      = anode_q;
    assign digitOut      = shadow_q[sel_q];
    assign frameStartOut = boundary;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Directed bench for display_scan_scheduler at SLOT_CYCLES=8, BLANK_CYCLES=2, 8 digits.
module tb_display_scan_scheduler;

    logic        clkIn = 1'b0;
    logic        rstNIn;
    logic [31:0] digitsIn;
    logic [7:0]  enMaskIn;
    logic        loadReqIn;
    logic        loadAckOut;
    logic [2:0]  selOut;
    logic [7:0]  anodeOut;
    logic [3:0]  digitOut;
    logic        frameStartOut;
`ifdef SCAN_DIM_PWM_EN
    logic [3:0]  dimIn;
`endif

    always #5 clkIn = ~clkIn;

    display_scan_scheduler #(
        .DIGIT_COUNT   (8),
        .DATA_WIDTH    (4),
        .CLK_FREQUENCY (64),
        .REFRESH_RATE  (1),
        .BLANK_CYCLES  (2)
    ) dut (
        .clkIn         (clkIn),
        .rstNIn        (rstNIn),
`ifdef SCAN_DIM_PWM_EN
        .dimIn         (dimIn),
`endif
        .digitsIn      (digitsIn),
        .enMaskIn      (enMaskIn),
        .loadReqIn     (loadReqIn),
        .loadAckOut    (loadAckOut),
        .selOut        (selOut),
        .anodeOut      (anodeOut),
        .digitOut      (digitOut),
        .frameStartOut (frameStartOut)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int          c;
    logic [31:0] m_dig;
    logic [7:0]  m_mask;
    int          m_lim;
    logic        m_ack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, c, obs, exp);
        end
    endtask

    task automatic model_reset();
        c      = 0;
        m_dig  = '0;
        m_mask = '0;
        m_lim  = 6;
        m_ack  = 1'b0;
    endtask

    // Checks n cycles against the frame model, then advances the model across each edge.
    task automatic run(input int n);
        int         slot, pos;
        logic [7:0] ea;
        for (int k = 0; k < n; k++) begin
            slot = (c % 64) / 8;
            pos  = c % 8;
            ea   = 8'hFF;
            if (pos >= 2 && m_mask[slot] && (pos - 2) < m_lim) ea[slot] = 1'b0;
            chk("sel",   32'(selOut),        32'(slot));
            chk("anode", 32'(anodeOut),      32'(ea));
            chk("digit", 32'(digitOut),      (m_dig >> (slot * 4)) & 32'hF);
            chk("frame", 32'(frameStartOut), 32'(c % 64 == 0));
            chk("ack",   32'(loadAckOut),    32'(m_ack));
            if (m_ack) loadReqIn = 1'b0;
            m_ack = 1'b0;
            if (c % 64 == 0) begin
                if (loadReqIn) begin
                    m_dig  = digitsIn;
                    m_mask = enMaskIn;
                    m_ack  = 1'b1;
                end
`ifdef SCAN_DIM_PWM_EN
                m_lim = (6 * (int'(dimIn) + 1)) >> 4;
`endif
            end
            @(negedge clkIn);
            c++;
        end
    endtask

    initial begin
        rstNIn    = 1'b1;
        digitsIn  = 32'h7654_3210;
        enMaskIn  = 8'hFF;
        loadReqIn = 1'b1;
`ifdef SCAN_DIM_PWM_EN
        dimIn     = 4'hF;
`endif
        model_reset();
        #2 rstNIn = 1'b0;
        repeat (2) @(negedge clkIn);
        chk("rst_anode", 32'(anodeOut),   32'hFF);
        chk("rst_sel",   32'(selOut),     32'h0);
        chk("rst_digit", 32'(digitOut),   32'h0);
        chk("rst_ack",   32'(loadAckOut), 32'h0);

        rstNIn = 1'b1;
        #1;
        chk("first_boundary", 32'(frameStartOut), 32'h1);
        run(1);
        chk("first_ack", 32'(loadAckOut), 32'h1);
        run(65);
        chk("slot0_drive", 32'(anodeOut), 32'hFE);
        run(24);
        chk("slot3_sel",   32'(selOut),   32'h3);
        chk("slot3_digit", 32'(digitOut), 32'h3);
        run(48);

        // Request mid-frame: must wait for the boundary at cycle 192.
        digitsIn  = 32'h89AB_CDEF;
        enMaskIn  = 8'hF5;
        loadReqIn = 1'b1;
        run(54);
        chk("late_boundary", 32'(frameStartOut), 32'h1);
        chk("late_old_data", 32'(digitOut),      32'h0);
        chk("late_no_ack",   32'(loadAckOut),    32'h0);
        run(1);
        chk("late_ack", 32'(loadAckOut), 32'h1);
        run(11);
        chk("dark_slot1", 32'(anodeOut), 32'hFF);
        run(24);
        chk("slot4_anode", 32'(anodeOut), 32'hEF);
        chk("slot4_digit", 32'(digitOut), 32'hB);
        run(128);

        // Reset during DRIVE of slot 4 with a request held through it.
        chk("pre_rst_anode", 32'(anodeOut), 32'hEF);
        digitsIn  = 32'h1357_2468;
        enMaskIn  = 8'h3C;
        loadReqIn = 1'b1;
        rstNIn    = 1'b0;
        #1;
        chk("async_anode", 32'(anodeOut),   32'hFF);
        chk("async_sel",   32'(selOut),     32'h0);
        chk("async_digit", 32'(digitOut),   32'h0);
        chk("async_ack",   32'(loadAckOut), 32'h0);
        repeat (2) @(negedge clkIn);
        rstNIn = 1'b1;
        model_reset();
        #1;
        chk("rel_boundary", 32'(frameStartOut), 32'h1);
        chk("rel_no_ack",   32'(loadAckOut),    32'h0);
        run(1);
        chk("rel_ack", 32'(loadAckOut), 32'h1);
        run(19);
        chk("rel_slot2_anode", 32'(anodeOut), 32'hFB);
        chk("rel_slot2_digit", 32'(digitOut), 32'h4);
        run(44);
        chk("rel_frame2", 32'(frameStartOut), 32'h1);
        chk("rel_ack_gone", 32'(loadAckOut),  32'h0);
        run(66);

`ifdef SCAN_DIM_PWM_EN
        dimIn = 4'd7;
        run(82);
        chk("dim7_lit", 32'(anodeOut), 32'hFB);
        run(1);
        chk("dim7_off", 32'(anodeOut), 32'hFF);
        run(37);
        dimIn = 4'hF;
        run(26);
        chk("dim15_lit_early", 32'(anodeOut), 32'hFB);
        run(3);
        chk("dim15_lit_late", 32'(anodeOut), 32'hFB);
        run(64);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
